// File: rtl/cfu_pkg.sv
// Shared CFU types and constants: response status codes, the L1 response word and latency limit.
package cfu_pkg;

    localparam int CFU_STATUS_W       = 3;
    localparam int CFU_L1_MAX_LATENCY = 15;
    localparam int CFU_RESP_DATA_W    = 32;

    typedef enum logic [CFU_STATUS_W-1:0] {
        CFU_OK           = 3'd0,
        CFU_ERROR_UNIMPL = 3'd1,
        CFU_ERROR_STATE  = 3'd2,
        CFU_ERROR_CUSTOM = 3'd7
    } cfu_status_t;

    typedef struct packed {
        cfu_status_t                 status;
        logic [CFU_RESP_DATA_W-1:0]  data;
    } cfu_resp_t;

    // Id fields are never narrower than one bit, even for a single CFU or no state contexts.
    function automatic int cfu_max2(input int n);
        return (n > 2) ? n : 2;
    endfunction

endpackage

// File: rtl/cvt12_resp_fifo.sv
// Synchronous response FIFO, W bits x DEPTH entries, head visible combinationally; 1-cycle write-to-read.
// Push while full is ignored unless a pop frees the slot in the same cycle.
module cvt12_resp_fifo #(
    parameter  int W     = 35,
    parameter  int DEPTH = 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_dat_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Indices wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[head_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_pop) begin
            head_d = wrap_inc(head_q);
        end
        if (do_push) begin
            tail_d = wrap_inc(tail_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= push_dat_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/cvt12_cfu.sv
// CFU-L2 to CFU-L1 adapter: forwards requests same cycle, queues L1 responses; accept->resp_valid CFU_LATENCY+1
// (CFU_LATENCY with CVT12_CFU_BYPASS_EN when the FIFO is empty). L2 backpressure absorbed by credits; L1 never stalls.
module cvt12_cfu
    import cfu_pkg::*;
#(
    parameter  int CFU_N_CFUS     = 1,
    parameter  int CFU_N_STATES   = 0,
    parameter  int CFU_LATENCY    = 0,
    parameter  int CFU_FUNC_ID_W  = 10,
    parameter  int CFU_DATA_W     = 32,
    localparam int CFU_CFU_ID_W   = $clog2(cfu_max2(CFU_N_CFUS)),
    localparam int CFU_STATE_ID_W = $clog2(cfu_max2(CFU_N_STATES))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CFU_CFU_ID_W-1:0]   req_cfu,
    input  logic [CFU_STATE_ID_W-1:0] req_state,
    input  logic [CFU_FUNC_ID_W-1:0]  req_func,
    input  logic [CFU_DATA_W-1:0]     req_data0,
    input  logic [CFU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [CFU_STATUS_W-1:0]   resp_status,
    output logic [CFU_DATA_W-1:0]     resp_data,
    output logic                      t_clk_en,
    output logic                      t_req_valid,
    output logic [CFU_CFU_ID_W-1:0]   t_req_cfu,
    output logic [CFU_STATE_ID_W-1:0] t_req_state,
    output logic [CFU_FUNC_ID_W-1:0]  t_req_func,
    output logic [CFU_DATA_W-1:0]     t_req_data0,
    output logic [CFU_DATA_W-1:0]     t_req_data1,
    input  logic                      t_resp_valid,
    input  logic [CFU_STATUS_W-1:0]   t_resp_status,
    input  logic [CFU_DATA_W-1:0]     t_resp_data
);

    localparam int DEPTH  = CFU_LATENCY + 1;
    localparam int CRED_W = $clog2(DEPTH + 1);
    localparam int RESP_W = CFU_STATUS_W + CFU_DATA_W;
    localparam int MASK_W = $clog2(CFU_L1_MAX_LATENCY + 1);

    logic [CRED_W-1:0] credits_q, credits_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              proto_err_q, proto_err_d;

    logic              accept;
    logic              pop;
    logic              exp_now;
    logic              masked;
    logic              bypass;
    logic              push;
    logic [RESP_W-1:0] in_word;
    logic [RESP_W-1:0] head_word;
    logic [RESP_W-1:0] out_word;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CRED_W-1:0] fifo_count;

    assign t_clk_en    = 1'b1;
    assign req_ready   = ~rst & (credits_q != '0);
    assign accept      = req_valid & req_ready;
    assign t_req_valid = accept;
    assign t_req_cfu   = req_cfu;
    assign t_req_state = req_state;
    assign t_req_func  = req_func;
    assign t_req_data0 = req_data0;
    assign t_req_data1 = req_data1;

    generate
        if (CFU_LATENCY == 0) begin : g_exp_none
            assign exp_now = accept;
        end else begin : g_exp_sr
            logic [CFU_LATENCY-1:0] exp_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    exp_q <= '0;
                end else begin
                    exp_q <= (exp_q << 1) | CFU_LATENCY'(accept);
                end
            end
            assign exp_now = exp_q[CFU_LATENCY-1];
        end
    endgenerate

    // After reset the expect pipe is empty, so responses to requests issued before reset
    // can still arrive for CFU_LATENCY cycles; those are dropped silently.
    assign masked = (mask_q != '0);
    assign mask_d = masked ? mask_q - MASK_W'(1) : '0;

    // A missing response still occupies a slot (flagged as custom error) so credits stay balanced;
    // an unexpected one is dropped so it can never overrun the FIFO.
    assign in_word = t_resp_valid ? {t_resp_status, t_resp_data}
                                  : {CFU_ERROR_CUSTOM, {CFU_DATA_W{1'b0}}};
    assign proto_err_d = proto_err_q | ((t_resp_valid != exp_now) & ~masked);

`ifdef CVT12_CFU_BYPASS_EN
    assign bypass   = ~rst & fifo_empty & exp_now & t_resp_valid & resp_ready;
    assign out_word = bypass ? in_word : head_word;
`else
    assign bypass   = 1'b0;
    assign out_word = head_word;
`endif

    assign push        = exp_now & ~bypass;
    assign resp_valid  = ~rst & (~fifo_empty | bypass);
    assign pop         = resp_valid & resp_ready;
    assign resp_status = proto_err_q ? CFU_ERROR_CUSTOM : out_word[RESP_W-1 -: CFU_STATUS_W];
    assign resp_data   = out_word[CFU_DATA_W-1:0];

    assign credits_d = credits_q - CRED_W'(accept) + CRED_W'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q   <= CRED_W'(DEPTH);
            mask_q      <= MASK_W'(CFU_LATENCY);
            proto_err_q <= 1'b0;
        end else begin
            credits_q   <= credits_d;
            mask_q      <= mask_d;
            proto_err_q <= proto_err_d;
        end
    end

    cvt12_resp_fifo #(
        .W     (RESP_W),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (in_word),
        .pop_i      (pop & ~bypass),
        .head_dat_o (head_word),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        (int'(credits_q) + int'(fifo_count) <= DEPTH) && !(fifo_full && credits_q != '0));

endmodule

// File: tb/tb_cvt12_cfu.sv
// Bench for cvt12_cfu: a LATENCY=2 instance against a queue-based response model, plus a LATENCY=0 instance.
module tb_cvt12_cfu;
    import cfu_pkg::*;

    localparam int L     = 2;
    localparam int DEPTH = L + 1;
`ifdef CVT12_CFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, resp_valid, resp_ready;
    logic [0:0]  req_cfu, req_state, t_req_cfu, t_req_state;
    logic [9:0]  req_func, t_req_func;
    logic [31:0] req_data0, req_data1, t_req_data0, t_req_data1, resp_data, t_resp_data;
    logic [2:0]  resp_status, t_resp_status;
    logic        t_clk_en, t_req_valid, t_resp_valid;

    logic        req_valid_0, req_ready_0, resp_valid_0, resp_ready_0;
    logic [0:0]  req_cfu_0, req_state_0, t_req_cfu_0, t_req_state_0;
    logic [9:0]  req_func_0, t_req_func_0;
    logic [31:0] req_data0_0, req_data1_0, t_req_data0_0, t_req_data1_0, resp_data_0, t_resp_data_0;
    logic [2:0]  resp_status_0;
    logic        t_clk_en_0, t_req_valid_0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] ref_fn(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
        return a + b + {22'd0, f};
    endfunction

    cvt12_cfu #(.CFU_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cfu(req_cfu), .req_state(req_state),
        .req_func(req_func), .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status), .resp_data(resp_data),
        .t_clk_en(t_clk_en), .t_req_valid(t_req_valid), .t_req_cfu(t_req_cfu), .t_req_state(t_req_state),
        .t_req_func(t_req_func), .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
        .t_resp_valid(t_resp_valid), .t_resp_status(t_resp_status), .t_resp_data(t_resp_data)
    );

    // Zero-latency subordinate wired combinationally to the second instance.
    cvt12_cfu #(.CFU_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_0), .req_ready(req_ready_0), .req_cfu(req_cfu_0), .req_state(req_state_0),
        .req_func(req_func_0), .req_data0(req_data0_0), .req_data1(req_data1_0),
        .resp_valid(resp_valid_0), .resp_ready(resp_ready_0), .resp_status(resp_status_0), .resp_data(resp_data_0),
        .t_clk_en(t_clk_en_0), .t_req_valid(t_req_valid_0), .t_req_cfu(t_req_cfu_0), .t_req_state(t_req_state_0),
        .t_req_func(t_req_func_0), .t_req_data0(t_req_data0_0), .t_req_data1(t_req_data1_0),
        .t_resp_valid(t_req_valid_0), .t_resp_status(CFU_OK), .t_resp_data(t_resp_data_0)
    );
    assign t_resp_data_0 = ref_fn(t_req_func_0, t_req_data0_0, t_req_data1_0);

    // Two-stage subordinate; it is not reset, so requests in flight at reset still answer afterwards.
    logic        pv0 = 1'b0, pv1 = 1'b0, inj;
    logic [31:0] pd0, pd1;
    always @(posedge clk) begin
        pv0 <= t_req_valid;
        pd0 <= ref_fn(t_req_func, t_req_data0, t_req_data1);
        pv1 <= pv0;
        pd1 <= pd0;
    end
    assign t_resp_valid  = pv1 | inj;
    assign t_resp_data   = inj ? 32'hBAD0_0BAD : pd1;
    assign t_resp_status = CFU_OK;

    typedef struct {
        int          t;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];
    int   n = 0;
    bit   err_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the LATENCY=2 instance: drive, predict from the model, compare, advance the model.
    task automatic cyc(input bit rv, input bit rr, input bit rnd, input bit injv);
        bit exp_rr, exp_rv, acc, pp;
        @(negedge clk);
        req_valid  = rv;
        resp_ready = rr;
        inj        = injv;
        if (rnd) begin
            req_func  = 10'($urandom);
            req_data0 = $urandom;
            req_data1 = $urandom;
            req_cfu   = 1'($urandom);
            req_state = 1'($urandom);
        end
        #1;
        exp_rr = (q.size() < DEPTH);
        exp_rv = (q.size() > 0) && ((n >= q[0].t + L + 1) || (BYP && rr && n == q[0].t + L));
        acc = rv && exp_rr;
        pp  = rr && exp_rv;
        chk("req_ready", req_ready, exp_rr);
        chk("resp_valid", resp_valid, exp_rv);
        chk("t_req_valid", t_req_valid, acc);
        if (acc) begin
            chk("t_req_func", t_req_func, req_func);
            chk("t_req_data0", t_req_data0, req_data0);
            chk("t_req_data1", t_req_data1, req_data1);
            chk("t_req_ids", {t_req_cfu, t_req_state}, {req_cfu, req_state});
        end
        if (pp) begin
            chk("resp_data", resp_data, q[0].d);
            chk("resp_status", resp_status, err_m ? CFU_ERROR_CUSTOM : CFU_OK);
            void'(q.pop_front());
        end
        if (acc) q.push_back('{n, ref_fn(req_func, req_data0, req_data1)});
        if (injv) err_m = 1'b1;
        n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; resp_ready = 1'b1; inj = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_t_req_valid", t_req_valid, 0);
        chk("rst_t_clk_en", t_clk_en, 1);
        q.delete();
        err_m = 1'b0;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        #1;
        chk("rel_req_ready", req_ready, 1);
        chk("rel_resp_valid", resp_valid, 0);
        n += 2;
    endtask

    initial begin
        req_valid = 0; resp_ready = 0; inj = 0; req_cfu = 0; req_state = 0;
        req_func = 0; req_data0 = 0; req_data1 = 0;
        req_valid_0 = 0; resp_ready_0 = 1; req_cfu_0 = 0; req_state_0 = 0;
        req_func_0 = 0; req_data0_0 = 0; req_data1_0 = 0;
        do_reset();
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);

        // Zero-latency instance: same-cycle response with bypass, one cycle later without.
        @(negedge clk);
        req_valid_0 = 1; req_func_0 = 10'h2A; req_data0_0 = $urandom; req_data1_0 = $urandom; req_cfu_0 = 1;
        #1;
        chk("l0_req_ready", req_ready_0, 1);
        chk("l0_t_req_valid", t_req_valid_0, 1);
        chk("l0_t_req_cfu", t_req_cfu_0, req_cfu_0);
        chk("l0_t_clk_en", t_clk_en_0, 1);
        chk("l0_same_valid", resp_valid_0, BYP);
`ifdef CVT12_CFU_BYPASS_EN
        chk("l0_same_data", resp_data_0, ref_fn(10'h2A, req_data0_0, req_data1_0));
`endif
        @(negedge clk);
        req_valid_0 = 0;
        #1;
        chk("l0_next_valid", resp_valid_0, !BYP);
        chk("l0_next_ready", req_ready_0, BYP);
`ifndef CVT12_CFU_BYPASS_EN
        chk("l0_next_data", resp_data_0, ref_fn(10'h2A, req_data0_0, req_data1_0));
        chk("l0_next_status", resp_status_0, CFU_OK);
`endif
        @(negedge clk);
        #1;
        chk("l0_idle_valid", resp_valid_0, 0);
        chk("l0_idle_ready", req_ready_0, 1);
        chk("l0_idle_state", t_req_state_0, req_state_0);

        // Single request func=3 data0=5 data1=7.
        req_func = 10'd3; req_data0 = 32'd5; req_data1 = 32'd7;
        cyc(1, 1, 0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0);

        // Three back-to-back with resp_ready low, then drain.
        for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0);
        for (int k = 0; k < 2; k++) cyc(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) cyc(0, 1, 1, 0);

        // Streaming: accept and pop in the same cycle once full.
        for (int k = 0; k < 12; k++) cyc(1, 1, 1, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0);

        // Reset with one response queued and two requests still in flight.
        for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0);
        do_reset();
        for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0);
        for (int k = 0; k < 4; k++) cyc(1, 1, 1, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0);

        // Spurious subordinate response sets the sticky protocol error.
        cyc(0, 1, 1, 1);
        cyc(0, 1, 1, 0);
        cyc(1, 1, 1, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 1, 0);

        do_reset();
        for (int k = 0; k < 2; k++) cyc(0, 1, 1, 0);
        for (int k = 0; k < 300; k++) cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 1, 0);
        for (int k = 0; k < 40 && q.size() > 0; k++) cyc(0, 1, 1, 0);
        chk("drain_empty", q.size(), 0);
        cyc(0, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
